vdp_io_initiator: RTL

CPU-side initiator for the VDP I/O port protocol: turns single-beat requests into Z80-style I/O bus cycles (IORQ_L/RD_L/WR_L) on ports 0xBE (data) and 0xBF (control/status). It sits between a bus host (CPU model, bootloader, or test sequencer) and the VDP port decoder. Strobe width and inter-cycle gap are set so that every access is seen by the decoder as exactly one transaction. It also sequences the two-byte control-port address/command write as one request.

---
 rtl/vdp_pkg.sv | 29 ++
 rtl/vdp_io_initiator.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/vdp_pkg.sv
// -----------------------------------------------------------------------------
// vdp_pkg
// Shared types and constants for the VDP I/O port initiator.
//   io_op_t      : request opcode carried on req_op (3 bits, codes 5..7 unused)
//   init_state_t : initiator bus-cycle FSM states
//   VDP_DATA_PORT / VDP_CTRL_PORT : low address bytes of the two VDP ports
// -----------------------------------------------------------------------------
package vdp_pkg;

    typedef enum logic [2:0] {
        WR_DATA  = 3'd0,
        RD_DATA  = 3'd1,
        WR_CTRL  = 3'd2,
        RD_STAT  = 3'd3,
        SET_ADDR = 3'd4
    } io_op_t;

    localparam logic [7:0] VDP_DATA_PORT = 8'hBE;
    localparam logic [7:0] VDP_CTRL_PORT = 8'hBF;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        STROBE = 3'd2,
        HOLD   = 3'd3,
        GAP    = 3'd4
    } init_state_t;

endpackage

// File: rtl/vdp_io_initiator.sv
// -----------------------------------------------------------------------------
// vdp_io_initiator
// Converts single-beat host requests into Z80-style I/O bus cycles on the VDP
// data (0xBE) and control/status (0xBF) ports. SET_ADDR is sequenced as two
// back-to-back control-port writes (low byte, then high byte).
//
// Ports:
//   clk, reset_L              clock, asynchronous active-low reset
//   req_valid/req_ready       request handshake; req_op/req_wdata request body
//   resp_valid/resp_data      one-cycle read-completion pulse, held read byte
//   busy                      high while a request is in flight
//   bus_addr, bus_data_out,
//   bus_data_oe, bus_data_in  I/O bus address and data
//   IORQ_L, RD_L, WR_L        active-low bus strobes
// -----------------------------------------------------------------------------
module vdp_io_initiator
    import vdp_pkg::*;
#(
    parameter int         STROBE_CYCLES = 2,
    parameter int         GAP_CYCLES    = 2,
    parameter logic [7:0] DATA_PORT     = VDP_DATA_PORT,
    parameter logic [7:0] CTRL_PORT     = VDP_CTRL_PORT
) (
    input  logic        clk,
    input  logic        reset_L,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [15:0] req_wdata,
    output logic        resp_valid,
    output logic [7:0]  resp_data,
    output logic        busy,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_data_out,
    output logic        bus_data_oe,
    input  logic [7:0]  bus_data_in,
    output logic        IORQ_L,
    output logic        RD_L,
    output logic        WR_L
);

    localparam int MAX_CYCLES = (STROBE_CYCLES > GAP_CYCLES) ? STROBE_CYCLES : GAP_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    init_state_t      state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             phase_reg, phase_next;
    io_op_t           op_reg;
    logic [15:0]      wdata_reg;
    logic [7:0]       rdata_reg;

    logic             op_load;
    logic             rdata_load;
    logic             is_read;
    logic             active;
    logic [7:0]       port_sel;
    logic [7:0]       wr_byte;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            phase_reg <= 1'b0;
            op_reg    <= WR_DATA;
            wdata_reg <= '0;
            rdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            phase_reg <= phase_next;
            if (op_load) begin
                op_reg    <= io_op_t'(req_op);
                wdata_reg <= req_wdata;
            end
            if (rdata_load) begin
                rdata_reg <= bus_data_in;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        phase_next = phase_reg;
        op_load    = 1'b0;
        rdata_load = 1'b0;
        case (state_reg)
            IDLE: begin
                phase_next = 1'b0;
                // Undefined opcodes 5..7 are consumed without any bus activity.
                if (req_valid && (req_op <= 3'd4)) begin
                    op_load    = 1'b1;
                    state_next = SETUP;
                end
            end
            SETUP: begin
                state_next = STROBE;
                cnt_next   = CNT_W'(STROBE_CYCLES - 1);
            end
            STROBE: begin
                if (cnt_reg == '0) begin
                    // Capture on the edge that closes the strobe window.
                    rdata_load = is_read;
                    state_next = HOLD;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            HOLD: begin
                state_next = GAP;
                cnt_next   = CNT_W'(GAP_CYCLES - 1);
            end
            GAP: begin
                if (cnt_reg == '0) begin
                    if ((op_reg == SET_ADDR) && !phase_reg) begin
                        phase_next = 1'b1;
                        state_next = SETUP;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs decode from state only, so the asynchronous reset (which forces
    // IDLE) drops the strobes and the data-bus drive without waiting for clk.
    assign is_read  = (op_reg == RD_DATA) || (op_reg == RD_STAT);
    assign active   = (state_reg != IDLE);
    assign port_sel = ((op_reg == WR_DATA) || (op_reg == RD_DATA)) ? DATA_PORT : CTRL_PORT;
    assign wr_byte  = ((op_reg == SET_ADDR) && phase_reg) ? wdata_reg[15:8] : wdata_reg[7:0];

    assign req_ready    = (state_reg == IDLE);
    assign busy         = active;
    assign bus_addr     = active ? {8'h00, port_sel} : 16'h0000;
    assign bus_data_out = (active && !is_read) ? wr_byte : 8'h00;
    assign bus_data_oe  = !is_read &&
                          ((state_reg == SETUP) || (state_reg == STROBE) || (state_reg == HOLD));
    assign IORQ_L       = !(state_reg == STROBE);
    assign RD_L         = !((state_reg == STROBE) && is_read);
    assign WR_L         = !((state_reg == STROBE) && !is_read);
    assign resp_valid   = (state_reg == HOLD) && is_read;
    assign resp_data    = rdata_reg;

endmodule
